// File: rtl/jtpopeye_objdma_gen.sv
// Object-table DMA engine: per-frame copy of main RAM into a double-buffered
// object table. Optional macro JTPOPEYE_DMA_CHKSUM_EN adds a table checksum.
module jtpopeye_objdma_gen #(
    parameter int          AW      = 10,
    parameter int          DW      = 8,
    parameter int          ENTRIES = 160,
    parameter int          BYTES   = 4,
    parameter int unsigned BASE    = 0,
    localparam int         XFER_N  = ENTRIES * BYTES,
    localparam int         CW      = $clog2(XFER_N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          VB,
    input  logic          busak_n,
    output logic          busrq_n,
    output logic          dma_cs,
    output logic [AW-1:0] AD_DMA,
    input  logic [DW-1:0] DD_DMA,
    input  logic [CW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          bank,
    output logic          done,
    output logic          ovr,
    output logic [7:0]    chksum
);

    localparam logic [CW-1:0] LAST   = CW'(XFER_N - 1);
    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam int            MEM_N  = 2 ** (CW + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_REL
    } st_t;

    st_t           r_st;
    logic          r_vb;
    logic          r_busrq_n;
    logic          r_dma_cs;
    logic [AW-1:0] r_ad;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_widx;
    logic          r_pend;
    logic          r_last;
    logic          r_abort;
    logic          r_bank;
    logic          r_done;
    logic          r_ovr;
    logic [DW-1:0] r_rd;
    logic [DW-1:0] r_mem [0:MEM_N-1];

    logic          w_vb_rise;
    logic          w_vb_fall;
    logic [AW-1:0] w_addr;
    logic          w_wr;
    logic [CW:0]   w_wa;
    logic          w_swap;

    assign w_vb_rise = VB & ~r_vb;
    assign w_vb_fall = ~VB & r_vb;
    assign w_addr    = BASE_A + AW'(r_cnt);

    // A byte lands only on a cen with the bus owned and no abort pending
    assign w_wr = cen & (r_st == ST_XFER) & ~busak_n
                & r_pend & ~w_vb_fall;
    assign w_wa = {~r_bank, r_widx};

    assign w_swap = cen & (r_st == ST_REL) & busak_n & ~r_abort;

    assign busrq_n = r_busrq_n;
    assign dma_cs  = r_dma_cs;
    assign AD_DMA  = r_ad;
    assign rd_data = r_rd;
    assign bank    = r_bank;
    assign done    = r_done;
    assign ovr     = r_ovr;

    // Transfer sequencer: bus request, address stream, release, bank swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st      <= ST_IDLE;
            r_vb      <= 1'b0;
            r_busrq_n <= 1'b1;
            r_dma_cs  <= 1'b0;
            r_ad      <= '0;
            r_cnt     <= '0;
            r_widx    <= '0;
            r_pend    <= 1'b0;
            r_last    <= 1'b0;
            r_abort   <= 1'b0;
            r_bank    <= 1'b0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
        end else if (cen) begin
            r_vb   <= VB;
            r_done <= 1'b0;
            case (r_st)
                ST_IDLE: begin
                    if (w_vb_rise) begin
                        r_st      <= ST_REQ;
                        r_busrq_n <= 1'b0;
                        r_abort   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (w_vb_fall) begin
                        r_st      <= ST_REL;
                        r_busrq_n <= 1'b1;
                        r_ovr     <= 1'b1;
                        r_abort   <= 1'b1;
                    end else if (!busak_n) begin
                        r_st   <= ST_XFER;
                        r_cnt  <= '0;
                        r_pend <= 1'b0;
                        r_last <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (w_vb_fall) begin
                        r_st      <= ST_REL;
                        r_busrq_n <= 1'b1;
                        r_dma_cs  <= 1'b0;
                        r_pend    <= 1'b0;
                        r_ovr     <= 1'b1;
                        r_abort   <= 1'b1;
                    end else if (busak_n) begin
                        // Bus lost: hold address, count and capture
                        r_dma_cs <= 1'b0;
                    end else if (r_last) begin
                        // Final byte is captured on this cen
                        r_dma_cs  <= 1'b0;
                        r_pend    <= 1'b0;
                        r_st      <= ST_REL;
                        r_busrq_n <= 1'b1;
                    end else begin
                        r_dma_cs <= 1'b1;
                        r_ad     <= w_addr;
                        r_widx   <= r_cnt;
                        r_pend   <= 1'b1;
                        if (r_cnt == LAST) begin
                            r_last <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_REL: begin
                    if (busak_n) begin
                        r_st <= ST_IDLE;
                        if (!r_abort) begin
                            r_bank <= ~r_bank;
                            r_done <= 1'b1;
                        end
                    end
                end
                default: r_st <= ST_IDLE;
            endcase
        end
    end

    // Shadow-bank fill; table contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_wa] <= DD_DMA;
        end
    end

    // Renderer read port, always from the active bank, every clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd <= '0;
        end else begin
            r_rd <= r_mem[{r_bank, rd_addr}];
        end
    end

`ifdef JTPOPEYE_DMA_CHKSUM_EN
    logic [7:0] w_byte8;
    logic [7:0] r_xor;
    logic [7:0] r_chk;

    if (DW >= 8) begin : g_trunc
        assign w_byte8 = DD_DMA[7:0];
    end else begin : g_zext
        assign w_byte8 = {{(8-DW){1'b0}}, DD_DMA};
    end

    assign chksum = r_chk;

    // Running XOR of the table; published only on a good bank swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor <= 8'h00;
            r_chk <= 8'h00;
        end else begin
            if (cen && r_st == ST_IDLE && w_vb_rise) begin
                r_xor <= 8'h00;
            end else if (w_wr) begin
                r_xor <= r_xor ^ w_byte8;
            end
            if (w_swap) begin
                r_chk <= r_xor;
            end
        end
    end
`else
    assign chksum = 8'h00;
`endif

endmodule
